// File: rtl/counter_wrap_tracker.sv
// counter_wrap_tracker: watches a 4-bit up/down counter stream, timestamps
// wrap and load events, queues them in a small FWFT FIFO for a valid/ready
// consumer, and keeps saturating wrap/drop statistics.
module counter_wrap_tracker #(
    parameter int DEPTH  = 4,
    parameter int TS_W   = 8,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_i,
    input  logic              mode_i,
    input  logic              load_i,
    input  logic              evt_ready,
    input  logic              clr_stats,
    output logic              evt_valid,
    output logic [1:0]        evt_type,
    output logic [3:0]        evt_value,
    output logic [TS_W-1:0]   evt_ts,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] drop_count,
    output logic              ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    localparam logic [1:0] T_UP   = 2'b01;
    localparam logic [1:0] T_DOWN = 2'b10;
    localparam logic [1:0] T_LOAD = 2'b11;

    logic [TS_W-1:0] ts;
    logic [3:0]      prev_cnt;
    logic            prev_mode, prev_load, prev_valid;

    logic [1:0]      mem_type  [DEPTH];
    logic [3:0]      mem_value [DEPTH];
    logic [TS_W-1:0] mem_ts    [DEPTH];
    logic [AW:0]     wptr, rptr;

    logic up_wrap, down_wrap, any_wrap, rec_vld;
    logic [1:0] rec_type;
    logic empty, full, pop, push, drop;

    // Wrap detection needs a valid previous sample taken without a load,
    // since a loaded value is not a count step.
    assign up_wrap   = prev_valid & ~prev_load &  prev_mode & (prev_cnt == 4'hF) & (cnt_i == 4'h0);
    assign down_wrap = prev_valid & ~prev_load & ~prev_mode & (prev_cnt == 4'h0) & (cnt_i == 4'hF);
    assign any_wrap  = up_wrap | down_wrap;
    assign rec_vld   = load_i | any_wrap;
    assign rec_type  = load_i ? T_LOAD : (up_wrap ? T_UP : T_DOWN);

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = ~empty & evt_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push  = rec_vld & (~full | pop);
    assign drop  = rec_vld & full & ~pop;

    assign evt_valid = ~empty;
    assign evt_type  = empty ? 2'b00      : mem_type [rptr[AW-1:0]];
    assign evt_value = empty ? 4'h0       : mem_value[rptr[AW-1:0]];
    assign evt_ts    = empty ? '0         : mem_ts   [rptr[AW-1:0]];

    // Free-running timestamp and one-cycle sample history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            prev_cnt   <= 4'h0;
            prev_mode  <= 1'b0;
            prev_load  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            ts         <= ts + 1'b1;
            prev_cnt   <= cnt_i;
            prev_mode  <= mode_i;
            prev_load  <= load_i;
            prev_valid <= 1'b1;
        end
    end

    // FIFO pointers; reset discards anything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_type [wptr[AW-1:0]] <= rec_type;
            mem_value[wptr[AW-1:0]] <= cnt_i;
            mem_ts   [wptr[AW-1:0]] <= ts;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            wrap_count <= '0;
            drop_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (any_wrap && wrap_count != STAT_MAX) wrap_count <= wrap_count + 1'b1;
            if (drop && drop_count != STAT_MAX)     drop_count <= drop_count + 1'b1;
            if (drop)                               ovf        <= 1'b1;
        end
    end
endmodule

// File: tb/tb_counter_wrap_tracker.sv
// Bench for counter_wrap_tracker: directed steps followed by random traffic,
// every cycle checked against a queue-based event model.
module tb_counter_wrap_tracker;
    localparam int DEPTH = 4;
    localparam int TS_W = 8;
    localparam int STAT_W = 8;
    localparam int TS_MOD = 1 << TS_W;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] cnt_i = 4'h0;
    logic mode_i = 1'b1;
    logic load_i = 1'b0;
    logic evt_ready = 1'b0;
    logic clr_stats = 1'b0;
    logic evt_valid;
    logic [1:0] evt_type;
    logic [3:0] evt_value;
    logic [TS_W-1:0] evt_ts;
    logic [STAT_W-1:0] wrap_count, drop_count;
    logic ovf;

    counter_wrap_tracker #(.DEPTH(DEPTH), .TS_W(TS_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .cnt_i(cnt_i), .mode_i(mode_i), .load_i(load_i),
        .evt_ready(evt_ready), .clr_stats(clr_stats), .evt_valid(evt_valid),
        .evt_type(evt_type), .evt_value(evt_value), .evt_ts(evt_ts),
        .wrap_count(wrap_count), .drop_count(drop_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int v; int ts; } rec_t;
    rec_t q[$];
    int m_ts = 0, m_wrap = 0, m_drop = 0, m_ovf = 0;
    int have = 0, l_cnt = 0, l_mode = 0, l_load = 0;
    int n_assert = 0, n_fail = 0;
    int saved_ts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance model by the spec rules for the current inputs, clock once, compare.
    task automatic tick();
        int upw, dnw, c, rt;
        rec_t r;
        if (rst) begin
            q.delete();
            m_ts = 0; m_wrap = 0; m_drop = 0; m_ovf = 0; have = 0;
        end else begin
            c = cnt_i;
            upw = (have && !l_load && l_mode == 1 && l_cnt == 15 && c == 0) ? 1 : 0;
            dnw = (have && !l_load && l_mode == 0 && l_cnt == 0 && c == 15) ? 1 : 0;
            if (evt_ready && q.size() > 0) void'(q.pop_front());
            rt = load_i ? 3 : (upw ? 1 : (dnw ? 2 : 0));
            if (clr_stats) begin
                m_wrap = 0; m_drop = 0; m_ovf = 0;
            end else if (upw || dnw) begin
                if (m_wrap < STAT_MAX) m_wrap++;
            end
            if (rt != 0) begin
                if (q.size() < DEPTH) begin
                    r.t = rt; r.v = c; r.ts = m_ts;
                    q.push_back(r);
                end else if (!clr_stats) begin
                    if (m_drop < STAT_MAX) m_drop++;
                    m_ovf = 1;
                end
            end
            m_ts = (m_ts + 1) % TS_MOD;
            l_cnt = c; l_mode = mode_i; l_load = load_i; have = 1;
        end
        @(posedge clk);
        #1;
        chk("evt_valid", evt_valid, (q.size() != 0) ? 1 : 0);
        chk("evt_type",  evt_type,  q.size() ? q[0].t  : 0);
        chk("evt_value", evt_value, q.size() ? q[0].v  : 0);
        chk("evt_ts",    evt_ts,    q.size() ? q[0].ts : 0);
        chk("wrap_count", wrap_count, m_wrap);
        chk("drop_count", drop_count, m_drop);
        chk("ovf", ovf, m_ovf);
    endtask

    initial begin
        int c;
        // Reset
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_valid", evt_valid, 0);
        chk("rst_wrap", wrap_count, 0);

        // Up-count 0..F,0
        evt_ready = 1'b1; mode_i = 1'b1;
        for (int i = 0; i < 16; i++) begin cnt_i = 4'(i); tick(); end
        saved_ts = m_ts;
        cnt_i = 4'h0; tick();
        chk("up_type", evt_type, 1);
        chk("up_value", evt_value, 0);
        chk("up_ts", evt_ts, saved_ts);
        chk("up_wrapcnt", wrap_count, 1);

        // Down-count 2,1,0,F then F->E
        mode_i = 1'b0;
        cnt_i = 4'h2; tick();
        cnt_i = 4'h1; tick();
        cnt_i = 4'h0; tick();
        cnt_i = 4'hF; tick();
        chk("dn_type", evt_type, 2);
        chk("dn_value", evt_value, 15);
        chk("dn_wrapcnt", wrap_count, 2);
        cnt_i = 4'hE; tick();
        chk("dn_norec", evt_valid, 0);

        // Load on an F->0 step: load record wins, wrap still counted
        mode_i = 1'b1; cnt_i = 4'hF; tick();
        cnt_i = 4'h0; load_i = 1'b1; tick();
        load_i = 1'b0;
        chk("ld_type", evt_type, 3);
        chk("ld_wrapcnt", wrap_count, 3);
        cnt_i = 4'h1; tick();

        // Six loads into a stalled FIFO
        evt_ready = 1'b0; cnt_i = 4'h5;
        for (int i = 0; i < 6; i++) begin load_i = 1'b1; cnt_i = 4'(5 + i); tick(); end
        load_i = 1'b0; tick();
        chk("ovf_drop", drop_count, 2);
        chk("ovf_flag", ovf, 1);
        // Full with simultaneous push and pop
        evt_ready = 1'b1; load_i = 1'b1; cnt_i = 4'h3; tick();
        load_i = 1'b0; evt_ready = 1'b0; tick();
        chk("pp_drop", drop_count, 2);
        chk("pp_occ", q.size(), 4);
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // 300 wraps saturate wrap_count, then clear
        mode_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cnt_i = 4'hF; tick();
            cnt_i = 4'h0; tick();
        end
        chk("sat_wrap", wrap_count, STAT_MAX);
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        chk("clr_wrap", wrap_count, 0);
        chk("clr_ovf", ovf, 0);

        // Reset with 3 queued records, then an F->0 across reset
        evt_ready = 1'b0; cnt_i = 4'h7;
        for (int i = 0; i < 3; i++) begin load_i = 1'b1; tick(); end
        load_i = 1'b0;
        chk("pre_rst_occ", q.size(), 3);
        cnt_i = 4'hF; mode_i = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_mid_valid", evt_valid, 0);
        cnt_i = 4'h0; tick();
        chk("post_rst_norec", evt_valid, 0);
        chk("post_rst_wrap", wrap_count, 0);

        // Random traffic following counter-like behaviour
        c = 0;
        for (int i = 0; i < 2000; i++) begin
            load_i = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode_i = ~mode_i;
            if (load_i) c = $urandom_range(0, 15);
            else c = mode_i ? (c + 1) % 16 : (c + 15) % 16;
            cnt_i = 4'(c);
            evt_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; clr_stats = 1'b0; load_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_wrap_tracker.md
Name: counter_wrap_tracker

Overview:
- Downstream consumer of the 4-bit up/down counter's output stream (dout, mode, load), sampled every clock.
- Detects three event types: up-wrap (F->0), down-wrap (0->F) and load.
- Timestamps each event and buffers it in a small FIFO for readout over a valid/ready handshake.
- Keeps saturating wrap and drop statistics for the scoreboard/debug path.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2.
- TS_W, 8, timestamp width; free-running cycle counter, wraps modulo 2^TS_W.
- STAT_W, 8, width of wrap_count and drop_count; both saturate.

Ports:
- clk  in  1  Single clock; all logic on posedge.
- rst  in  1  Synchronous, active-high reset.
- cnt_i  in  4  Counter dout.
- mode_i  in  1  Counter direction; 1 = up, 0 = down.
- load_i  in  1  Counter load strobe.
- evt_ready  in  1  Consumer accepts the head record.
- clr_stats  in  1  Synchronous clear of wrap_count, drop_count and ovf.
- evt_valid  out  1  FIFO non-empty.
- evt_type  out  2  Head record type: 01 up-wrap, 10 down-wrap, 11 load. 00 is never stored.
- evt_value  out  4  Head record counter value.
- evt_ts  out  TS_W  Head record timestamp.
- wrap_count  out  STAT_W  Total wraps detected, saturating.
- drop_count  out  STAT_W  Events lost to a full FIFO, saturating.
- ovf  out  1  Sticky; set on first drop.

Behaviour:
- Reset (rst=1 at posedge), effective next cycle:
  - FIFO emptied; evt_valid=0.
  - evt_type/evt_value/evt_ts=0.
  - wrap_count=0, drop_count=0, ovf=0.
  - Timestamp counter ts=0; prev_valid=0.
  - Reset mid-operation discards all queued records.
- Timestamp: ts increments every non-reset cycle and wraps FF->00 (TS_W=8).
- Sample history: prev_cnt, prev_mode and prev_load register cnt_i, mode_i and load_i each cycle; prev_valid is set 1 the cycle after reset.
- Detection in cycle t, requires prev_valid=1:
  - up_wrap: prev_load=0 & prev_mode=1 & prev_cnt=F & cnt_i=0.
  - down_wrap: prev_load=0 & prev_mode=0 & prev_cnt=0 & cnt_i=F.
  - load_evt: load_i=1. Does not require prev_valid, but is suppressed during rst.
- Record generation:
  - At most one record per cycle; load_evt has priority over a wrap.
  - Record fields: {type, value, ts}. value = cnt_i in cycle t; ts = ts value in cycle t.
  - wrap_count increments on any detected wrap, even when a load record wins the slot.
- FIFO, first-word-fall-through:
  - A record detected in cycle t is visible at evt_valid/evt_* in cycle t+1 if the FIFO was empty.
  - Pop when evt_valid & evt_ready. evt_* hold stable while evt_valid=1 and evt_ready=0.
  - Push and pop in the same cycle: both take effect. When full, the pop frees the slot and the push is accepted, so no drop.
  - Full with no pop and a new record: record discarded, drop_count+1 (saturating), ovf=1.
  - Empty with evt_ready=1: no effect.
- Statistics:
  - wrap_count and drop_count hold at 2^STAT_W-1 once saturated.
  - clr_stats=1 zeroes both counts and ovf; it has priority over a same-cycle increment.
  - clr_stats does not affect the FIFO.
- Pointer arithmetic: log2(DEPTH)+1-bit read/write pointers; full/empty are derived from the MSB difference.

Test Plan:
- Reset, then cnt_i up-counts 0..F,0 with mode=1, load=0, evt_ready=1 -> exactly one record {01, 0, ts of the F->0 cycle} appears one cycle later; wrap_count=1.
- mode=0, cnt_i 2,1,0,F -> record {10, F}; wrap_count increments; a following F->E transition produces no record.
- load_i=1 in the same cycle cnt_i goes F->0 (prev_mode=1) -> only a {11, 0, ts} record is stored; wrap_count still increments.
- evt_ready=0 with 6 load pulses, DEPTH=4 -> 4 records held, drop_count=2, ovf=1. Raise evt_ready -> records drain in order with the original timestamps.
- FIFO full with a push and pop in the same cycle -> no drop; occupancy stays 4.
- 300 wraps with no clr_stats -> wrap_count=FF (saturated). Pulse clr_stats -> wrap_count=0, ovf=0. Assert rst with 3 records queued -> evt_valid=0 next cycle, and the first post-reset sample generates no wrap record.
